// File: rtl/nes_cpu_bus_if.sv
// rtl/nes_cpu_bus_if.sv - CPU-side bus bundle between the 6502 core and the bus responder
//
// Signals:
//   addr      CPU address (master -> slave)
//   cpu_we    CPU write strobe (master -> slave)
//   cpu_dout  CPU write data (master -> slave)
//   cpu_din   registered read data (slave -> master)
//   rdy       CPU may advance, 0 while DMA stalls it (slave -> master)
interface nes_cpu_bus_if;
    logic [15:0] addr;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        rdy;

    modport master (output addr, cpu_we, cpu_dout, input cpu_din, rdy);
    modport slave  (input addr, cpu_we, cpu_dout, output cpu_din, rdy);
endinterface

// File: rtl/nes_cpu_bus.sv
// rtl/nes_cpu_bus.sv - 6502 bus responder: work RAM, PPU/PRG routing, $4014 OAM DMA
//
// Optional feature macro: NES_OPEN_BUS_EN (unmapped reads/DMA sources return the last bus value;
// without it they return 8'h00).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   bus (slave)         addr/cpu_we/cpu_dout in, cpu_din/rdy out
//   ppu_reg/re/we/wdata PPU register select and strobes, ppu_rdata read back same cycle
//   prg_addr/prg_rdata  cartridge PRG window ($8000-$FFFF), combinational read
//   oam_we/oam_wdata    OAM byte stream produced by the DMA engine
module nes_cpu_bus #(
    parameter int RAM_AW = 11,
    parameter int PRG_AW = 15
) (
    input  logic              clk,
    input  logic              rst,
    nes_cpu_bus_if.slave      bus,
    output logic [2:0]        ppu_reg,
    output logic              ppu_re,
    output logic              ppu_we,
    output logic [7:0]        ppu_wdata,
    input  logic [7:0]        ppu_rdata,
    output logic [PRG_AW-1:0] prg_addr,
    input  logic [7:0]        prg_rdata,
    output logic              oam_we,
    output logic [7:0]        oam_wdata
);
    typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;

    state_t      state;
    logic [7:0]  page;
    logic [7:0]  cnt;
    logic        rdy_q;
    logic [7:0]  cpu_din_q;
    logic [7:0]  ram [0:(1<<RAM_AW)-1];

    logic        in_ram, in_ppu, in_prg, is_dma_reg;
    logic        src_ram, src_prg;
    logic [7:0]  rd_data, dma_rd, unmapped_rd, unmapped_dma;
    logic [RAM_AW-1:0] dma_ram_addr;
    logic [PRG_AW-1:0] dma_prg_addr;

    assign in_ram     = (bus.addr[15:13] == 3'b000);
    assign in_ppu     = (bus.addr[15:13] == 3'b001);
    assign in_prg     = bus.addr[15];
    assign is_dma_reg = (bus.addr == 16'h4014);

    assign src_ram      = (page < 8'h20);
    assign src_prg      = page[7];
    assign dma_ram_addr = RAM_AW'({page, cnt});
    assign dma_prg_addr = PRG_AW'({page, cnt});

    // rdy_q is low exactly while the DMA engine owns the bus, so it gates every CPU effect.
    assign ppu_reg   = bus.addr[2:0];
    assign ppu_re    = rdy_q && in_ppu && !bus.cpu_we;
    assign ppu_we    = rdy_q && in_ppu && bus.cpu_we;
    assign ppu_wdata = bus.cpu_dout;
    assign prg_addr  = (state == READ && src_prg) ? dma_prg_addr : bus.addr[PRG_AW-1:0];

    assign bus.rdy     = rdy_q;
    assign bus.cpu_din = cpu_din_q;

`ifdef NES_OPEN_BUS_EN
    // Last value seen on the data bus: read data or the most recent CPU write data.
    logic [7:0] bus_last;
    assign unmapped_rd  = bus_last;
    assign unmapped_dma = oam_wdata;
`else
    assign unmapped_rd  = 8'h00;
    assign unmapped_dma = 8'h00;
`endif

    always_comb begin
        rd_data = unmapped_rd;
        if (in_ram)      rd_data = ram[bus.addr[RAM_AW-1:0]];
        else if (in_ppu) rd_data = ppu_rdata;
        else if (in_prg) rd_data = prg_rdata;
    end

    always_comb begin
        dma_rd = unmapped_dma;
        if (src_ram)      dma_rd = ram[dma_ram_addr];
        else if (src_prg) dma_rd = prg_rdata;
    end

    // Work RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (rdy_q && bus.cpu_we && in_ram)
            ram[bus.addr[RAM_AW-1:0]] <= bus.cpu_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            page      <= 8'h00;
            cnt       <= 8'h00;
            rdy_q     <= 1'b1;
            oam_we    <= 1'b0;
            oam_wdata <= 8'h00;
            cpu_din_q <= 8'h00;
`ifdef NES_OPEN_BUS_EN
            bus_last  <= 8'h00;
`endif
        end else begin
            if (rdy_q) begin
                if (!bus.cpu_we)
                    cpu_din_q <= rd_data;
`ifdef NES_OPEN_BUS_EN
                bus_last <= bus.cpu_we ? bus.cpu_dout : rd_data;
`endif
            end
            case (state)
                IDLE: begin
                    oam_we <= 1'b0;
                    if (bus.cpu_we && is_dma_reg) begin
                        page  <= bus.cpu_dout;
                        cnt   <= 8'h00;
                        rdy_q <= 1'b0;
                        state <= ALIGN;
                    end
                end
                ALIGN: state <= READ;
                READ: begin
                    oam_wdata <= dma_rd;
                    oam_we    <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    oam_we <= 1'b0;
                    cnt    <= cnt + 8'h01;
                    // Releasing rdy here makes it high in the cycle right after the last WRITE.
                    if (cnt == 8'hFF) begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nes_cpu_bus.sv
// tb/tb_nes_cpu_bus.sv - directed self-checking bench for nes_cpu_bus
module tb_nes_cpu_bus;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ppu_reg;
    logic        ppu_re, ppu_we;
    logic [7:0]  ppu_wdata, ppu_rdata;
    logic [14:0] prg_addr;
    logic [7:0]  prg_rdata;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    nes_cpu_bus_if bus();

    // Cartridge model: byte = low address byte XOR $C8 ($7FFC -> $34, $0001 -> $C9).
    assign prg_rdata = prg_addr[7:0] ^ 8'hC8;

    nes_cpu_bus dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ppu_reg(ppu_reg), .ppu_re(ppu_re), .ppu_we(ppu_we),
        .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata),
        .prg_addr(prg_addr), .prg_rdata(prg_rdata),
        .oam_we(oam_we), .oam_wdata(oam_wdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic we, input logic [7:0] d);
        bus.addr = a;
        bus.cpu_we = we;
        bus.cpu_dout = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ppu_rdata = 8'h00;
        drive(16'h0000, 1'b0, 8'h00);
        step;
        step;
        n_cmp++; if (bus.cpu_din !== 8'h00) begin n_bad++; $display("FAIL reset_cpu_din: got %h want 00", bus.cpu_din); end
        n_cmp++; if (bus.rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", bus.rdy); end
        n_cmp++; if (oam_we !== 1'b0) begin n_bad++; $display("FAIL reset_oam_we: got %b want 0", oam_we); end
        n_cmp++; if (oam_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_oam_wdata: got %h want 00", oam_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_ram_mirror;
        drive(16'h0005, 1'b1, 8'h5A); step;
        drive(16'h0805, 1'b0, 8'h00); step;
        n_cmp++; if (bus.cpu_din !== 8'h5A) begin n_bad++; $display("FAIL mirror_0805: got %h want 5a", bus.cpu_din); end
        drive(16'h1805, 1'b0, 8'h00); step;
        n_cmp++; if (bus.cpu_din !== 8'h5A) begin n_bad++; $display("FAIL mirror_1805: got %h want 5a", bus.cpu_din); end
    endtask

    task automatic test_ppu;
        ppu_rdata = 8'h80;
        drive(16'h2002, 1'b0, 8'h00); #1;
        n_cmp++; if (ppu_re !== 1'b1) begin n_bad++; $display("FAIL ppu_re: got %b want 1", ppu_re); end
        n_cmp++; if (ppu_reg !== 3'd2) begin n_bad++; $display("FAIL ppu_reg: got %0d want 2", ppu_reg); end
        n_cmp++; if (ppu_we !== 1'b0) begin n_bad++; $display("FAIL ppu_we_on_read: got %b want 0", ppu_we); end
        step;
        n_cmp++; if (bus.cpu_din !== 8'h80) begin n_bad++; $display("FAIL ppu_read_data: got %h want 80", bus.cpu_din); end
        drive(16'h2007, 1'b1, 8'h3C); #1;
        n_cmp++; if ({ppu_we, ppu_re, ppu_wdata} !== {1'b1, 1'b0, 8'h3C})
            begin n_bad++; $display("FAIL ppu_write: got we=%b re=%b d=%h want we=1 re=0 d=3c", ppu_we, ppu_re, ppu_wdata); end
        step;
    endtask

    task automatic test_prg;
        drive(16'hFFFC, 1'b0, 8'h00); #1;
        n_cmp++; if (prg_addr !== 15'h7FFC) begin n_bad++; $display("FAIL prg_addr: got %h want 7ffc", prg_addr); end
        step;
        n_cmp++; if (bus.cpu_din !== 8'h34) begin n_bad++; $display("FAIL prg_read: got %h want 34", bus.cpu_din); end
    endtask

    task automatic test_back_to_back;
        drive(16'h0010, 1'b1, 8'hA1); step;
        drive(16'h0010, 1'b0, 8'h00); step;
        n_cmp++; if (bus.cpu_din !== 8'hA1) begin n_bad++; $display("FAIL b2b_raw: got %h want a1", bus.cpu_din); end
        drive(16'h8001, 1'b0, 8'h00); step;
        n_cmp++; if (bus.cpu_din !== 8'hC9) begin n_bad++; $display("FAIL b2b_prg: got %h want c9", bus.cpu_din); end
        drive(16'h0005, 1'b0, 8'h00); step;
        n_cmp++; if (bus.cpu_din !== 8'h5A) begin n_bad++; $display("FAIL b2b_ram: got %h want 5a", bus.cpu_din); end
        ppu_rdata = 8'h42;
        drive(16'h3FFA, 1'b0, 8'h00); step;
        n_cmp++; if (bus.cpu_din !== 8'h42) begin n_bad++; $display("FAIL b2b_ppu_mirror: got %h want 42", bus.cpu_din); end
    endtask

    task automatic test_dma;
        int stall = 0, pulses = 0, bad_data = 0, strobes = 0;
        bit done = 0;
        for (int i = 0; i < 256; i++) begin
            drive(16'h0200 + 16'(i), 1'b1, 8'(i)); step;
        end
        drive(16'h0000, 1'b1, 8'h11); step;
        drive(16'h4014, 1'b1, 8'h02); step;
        for (int c = 0; c < 1000 && !done; c++) begin
            if (bus.rdy) begin
                done = 1;
                drive(16'h0000, 1'b0, 8'h00);
            end else begin
                stall++;
                if (oam_we) begin
                    if (oam_wdata !== 8'(pulses)) bad_data++;
                    pulses++;
                end
                case (c % 3)
                    0:       drive(16'h0000, 1'b1, 8'hEE);
                    1:       drive(16'h2001, 1'b1, 8'h0F);
                    default: drive(16'h4014, 1'b1, 8'h05);
                endcase
                #1;
                if (ppu_we || ppu_re) strobes++;
                step;
            end
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL dma_timeout: rdy stayed low past 1000 cycles"); end
        n_cmp++; if (stall !== 513) begin n_bad++; $display("FAIL dma_stall: got %0d want 513", stall); end
        n_cmp++; if (pulses !== 256) begin n_bad++; $display("FAIL dma_pulses: got %0d want 256", pulses); end
        n_cmp++; if (bad_data !== 0) begin n_bad++; $display("FAIL dma_data_order: got %0d wrong bytes want 0", bad_data); end
        n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL dma_ppu_strobes: got %0d want 0", strobes); end
        step;
        n_cmp++; if (bus.cpu_din !== 8'h11) begin n_bad++; $display("FAIL dma_ram_protect: got %h want 11", bus.cpu_din); end
    endtask

    task automatic test_reset_mid_dma;
        int stall = 0, pulses = 0, bad_data = 0;
        logic [7:0] first = 8'hXX;
        bit done = 0;
        drive(16'h0205, 1'b0, 8'h00); step;
        drive(16'h4014, 1'b1, 8'h02); step;
        drive(16'h0000, 1'b0, 8'h00);
        for (int k = 1; k < 100; k++) step;
        n_cmp++; if (bus.rdy !== 1'b0) begin n_bad++; $display("FAIL mid_dma_rdy: got %b want 0", bus.rdy); end
        rst = 1'b1; step; rst = 1'b0;
        n_cmp++; if ({bus.rdy, oam_we, bus.cpu_din} !== {1'b1, 1'b0, 8'h00})
            begin n_bad++; $display("FAIL mid_dma_reset: got rdy=%b oam_we=%b din=%h want 1 0 00", bus.rdy, oam_we, bus.cpu_din); end
        drive(16'h4014, 1'b1, 8'h02); step;
        drive(16'h0000, 1'b0, 8'h00);
        for (int c = 0; c < 1000 && !done; c++) begin
            if (bus.rdy) done = 1;
            else begin
                stall++;
                if (oam_we) begin
                    if (pulses == 0) first = oam_wdata;
                    if (oam_wdata !== 8'(pulses)) bad_data++;
                    pulses++;
                end
                step;
            end
        end
        n_cmp++; if (first !== 8'h00) begin n_bad++; $display("FAIL restart_first: got %h want 00", first); end
        n_cmp++; if ({stall, pulses, bad_data} !== {32'd513, 32'd256, 32'd0})
            begin n_bad++; $display("FAIL restart_dma: got stall=%0d pulses=%0d bad=%0d want 513 256 0", stall, pulses, bad_data); end
    endtask

    task automatic test_open_bus;
        logic [7:0] exp;
`ifdef NES_OPEN_BUS_EN
        exp = 8'h77;
`else
        exp = 8'h00;
`endif
        drive(16'h0005, 1'b0, 8'h00); step;
        drive(16'h4016, 1'b1, 8'h77); step;
        drive(16'h6000, 1'b0, 8'h00); step;
        n_cmp++; if (bus.cpu_din !== exp) begin n_bad++; $display("FAIL open_bus: got %h want %h", bus.cpu_din, exp); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_ram_mirror;
        test_ppu;
        test_prg;
        test_back_to_back;
        test_dma;
        test_reset_mid_dma;
        test_open_bus;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
